// File: rtl/c766_pkg.sv
// Shared constants and types for the C766 evaluation arbiter.
// Holds the truth table, the vector width and the controller state encoding.
package c766_pkg;

  localparam logic [15:0] TT = 16'hC766;
  localparam int unsigned VecW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  // Row 0 of the truth table sits in the MSB of TT.
  function automatic logic tt_eval(input logic [VecW-1:0] idx);
    return TT[4'd15 - idx];
  endfunction

endpackage

// File: rtl/c766_core.sv
// Purely combinational 4-input evaluator for the C766 truth table.
module c766_core
  import c766_pkg::*;
(
  input  logic in1_i,
  input  logic in2_i,
  input  logic in3_i,
  input  logic in4_i,
  output logic f_o
);

  assign f_o = tt_eval({in1_i, in2_i, in3_i, in4_i});

endmodule

// File: rtl/c766_eval_arbiter.sv
// Round-robin arbiter feeding one shared C766 evaluator; the granted vector is latched,
// held for SETTLE cycles, sampled, and returned through a valid/ready response port.
module c766_eval_arbiter
  import c766_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SETTLE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [VecW*NREQ-1:0]     req_vec,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_out,
  output logic                     busy
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = 4;

  state_e            state_q;
  logic [IdW-1:0]    rr_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic [VecW-1:0]   vec_q;

  logic              grant_found;
  logic [IdW-1:0]    grant_idx;
  logic [VecW-1:0]   grant_vec;
  logic [IdW-1:0]    rr_next;
  logic              core_f;

  // First valid requester at or after rr_ptr_q, wrapping.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IdW'(cand);
        grant_vec   = req_vec[cand*VecW +: VecW];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == StIdle) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign rr_next = (rsp_id == IdW'(NREQ - 1)) ? '0 : rsp_id + IdW'(1);

  // Evaluator only ever sees the latched vector, never the live request bus.
  c766_core u_core (
    .in1_i (vec_q[3]),
    .in2_i (vec_q[2]),
    .in3_i (vec_q[1]),
    .in4_i (vec_q[0]),
    .f_o   (core_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      vec_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_out   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            vec_q   <= grant_vec;
            rsp_id  <= grant_idx;
            cnt_q   <= CntW'(SETTLE - 1);
            busy    <= 1'b1;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            rsp_out   <= core_f;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr_q  <= rr_next;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_c766_eval_arbiter.sv
// Self-checking bench for c766_eval_arbiter: transaction-level model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_c766_eval_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid_a, req_ready_a, req_valid_b, req_ready_b;
  logic [15:0] req_vec_a, req_vec_b;
  logic        rsp_valid_a, rsp_ready_a, rsp_out_a, busy_a;
  logic        rsp_valid_b, rsp_ready_b, rsp_out_b, busy_b;
  logic [1:0]  rsp_id_a, rsp_id_b;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  c766_eval_arbiter #(.NREQ(4), .SETTLE(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid_a),
    .req_vec   (req_vec_a),
    .req_ready (req_ready_a),
    .rsp_valid (rsp_valid_a),
    .rsp_ready (rsp_ready_a),
    .rsp_id    (rsp_id_a),
    .rsp_out   (rsp_out_a),
    .busy      (busy_a)
  );

  c766_eval_arbiter #(.NREQ(4), .SETTLE(1)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid_b),
    .req_vec   (req_vec_b),
    .req_ready (req_ready_b),
    .rsp_valid (rsp_valid_b),
    .rsp_ready (rsp_ready_b),
    .rsp_id    (rsp_id_b),
    .rsp_out   (rsp_out_b),
    .busy      (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic tt_bit(input logic [3:0] idx);
    logic [15:0] t;
    t = 16'hC766;
    return t[15 - idx];
  endfunction

  // Transaction model per instance: idle -> (grant) -> result due settle+1 cycles later.
  bit   m_busy [2] = '{0, 0};
  int   m_rr   [2] = '{0, 0};
  int   m_acc  [2] = '{0, 0};
  int   m_id   [2] = '{0, 0};
  logic m_res  [2] = '{0, 0};

  task automatic check_unit(input int u, input int settle, input logic [3:0] rv,
                            input logic [15:0] vec, input logic rr, input logic [3:0] d_rdy,
                            input logic d_val, input logic [1:0] d_id, input logic d_out,
                            input logic d_busy);
    logic [3:0] exp_rdy;
    int         win;
    bit         found;
    bit         due;
    string      p;
    p = $sformatf("u%0d", u);
    if (!rst_n) begin
      chk({p, "_rst_ready"}, d_rdy, 0);
      chk({p, "_rst_valid"}, d_val, 0);
      chk({p, "_rst_busy"}, d_busy, 0);
      chk({p, "_rst_id"}, d_id, 0);
      chk({p, "_rst_out"}, d_out, 0);
      m_busy[u] = 0;
      m_rr[u]   = 0;
      return;
    end
    if (!m_busy[u]) begin
      exp_rdy = '0;
      found   = 0;
      win     = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && rv[(m_rr[u] + k) % 4]) begin
          found = 1;
          win   = (m_rr[u] + k) % 4;
        end
      end
      if (found) exp_rdy[win] = 1'b1;
      chk({p, "_idle_ready"}, d_rdy, exp_rdy);
      chk({p, "_idle_valid"}, d_val, 0);
      chk({p, "_idle_busy"}, d_busy, 0);
      if (found) begin
        m_busy[u] = 1;
        m_id[u]   = win;
        m_acc[u]  = cyc;
        m_res[u]  = tt_bit(vec[win*4 +: 4]);
      end
    end else begin
      due = (cyc >= m_acc[u] + settle + 1);
      chk({p, "_busy_ready"}, d_rdy, 0);
      chk({p, "_busy_busy"}, d_busy, 1);
      chk({p, "_rsp_valid"}, d_val, due);
      if (due) begin
        chk({p, "_rsp_id"}, d_id, m_id[u]);
        chk({p, "_rsp_out"}, d_out, m_res[u]);
        if (rr) begin
          m_busy[u] = 0;
          m_rr[u]   = (m_id[u] + 1) % 4;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check_unit(0, 4, req_valid_a, req_vec_a, rsp_ready_a, req_ready_a, rsp_valid_a, rsp_id_a,
               rsp_out_a, busy_a);
    check_unit(1, 1, req_valid_b, req_vec_b, rsp_ready_b, req_ready_b, rsp_valid_b, rsp_id_b,
               rsp_out_b, busy_b);
  end

  task automatic wait_grant_a(input int id);
    bit ok = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (req_ready_a[id]) begin
        ok = 1;
        break;
      end
    end
    chk("grant_wait", ok, 1);
  endtask

  task automatic wait_rsp_a();
    bit ok = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (rsp_valid_a) begin
        ok = 1;
        break;
      end
    end
    chk("rsp_wait", ok, 1);
  endtask

  task automatic do_txn(input int id, input logic [3:0] v, input bit scramble, output int lat,
                        output logic [1:0] rid, output logic res);
    int acc;
    req_valid_a[id] = 1'b1;
    req_vec_a[id*4 +: 4] = v;
    wait_grant_a(id);
    acc = cyc;
    @(posedge clk); #1;
    req_valid_a[id] = 1'b0;
    if (scramble) req_vec_a[id*4 +: 4] = ~v;
    wait_rsp_a();
    lat = cyc - acc;
    rid = rsp_id_a;
    res = rsp_out_a;
    @(posedge clk); #1;
  endtask

  logic [3:0] vecs029 [5] = '{4'b0000, 4'b0011, 4'b0101, 4'b1010, 4'b1111};
  logic       exp029  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       exp_tt  [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  int         exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    int         lat;
    logic [1:0] rid;
    logic       res;
    int         grants [$];
    int         acc_b [$];
    int         rsp_b [$];
    int         seen;

    rst_n = 1'b0;
    req_valid_a = '0; req_vec_a = '0; rsp_ready_a = 1'b1;
    req_valid_b = '0; req_vec_b = '0; rsp_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_busy", busy_a, 0);
    chk("reset_valid", rsp_valid_a, 0);

    // Single requester, fixed vectors.
    for (int i = 0; i < 5; i++) begin
      do_txn(0, vecs029[i], 0, lat, rid, res);
      chk("r0_latency", lat, 5);
      chk("r0_id", rid, 0);
      chk("r0_out", res, exp029[i]);
    end

    // Round-robin order from a fresh reset with everyone requesting.
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    req_vec_a = 16'h3A5C;
    req_valid_a = 4'hF;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready_a != '0) begin
        chk("rr_onehot", $countones(req_ready_a), 1);
        for (int b = 0; b < 4; b++) if (req_ready_a[b]) grants.push_back(b);
        if (grants.size() >= 5) break;
      end
    end
    @(posedge clk); #1 req_valid_a = '0;
    wait_rsp_a();
    @(posedge clk); #1;
    chk("rr_grant_count", grants.size(), 5);
    if (grants.size() == 5) begin
      for (int k = 0; k < 5; k++) chk($sformatf("rr_order_%0d", k), grants[k], exp_order[k]);
    end

    // Backpressure in RESP.
    rsp_ready_a = 1'b0;
    req_vec_a[15:12] = 4'b0110;
    req_valid_a[3] = 1'b1;
    wait_grant_a(3);
    @(posedge clk); #1;
    req_valid_a[3] = 1'b0;
    req_vec_a[3:0] = 4'b0000;
    req_valid_a[0] = 1'b1;
    wait_rsp_a();
    chk("hold_id", rsp_id_a, 3);
    chk("hold_out", rsp_out_a, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid_a, 1);
      chk("hold_id", rsp_id_a, 3);
      chk("hold_out", rsp_out_a, 1);
      chk("hold_ready", req_ready_a, 0);
    end
    @(posedge clk); #1 rsp_ready_a = 1'b1;
    @(negedge clk);
    chk("hs_valid", rsp_valid_a, 1);
    @(negedge clk);
    chk("resume_grant", req_ready_a, 4'b0001);
    @(posedge clk); #1 req_valid_a[0] = 1'b0;
    wait_rsp_a();
    @(posedge clk); #1;

    // Reset in the second SETTLE cycle aborts the job.
    req_vec_a[11:8] = 4'b1111;
    req_valid_a[2] = 1'b1;
    wait_grant_a(2);
    @(posedge clk); #1 req_valid_a[2] = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", rsp_valid_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_ready", req_ready_a, 0);
    chk("abort_id", rsp_id_a, 0);
    chk("abort_out", rsp_out_a, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid_a) seen++;
    end
    chk("abort_no_rsp", seen, 0);
    @(posedge clk); #1 req_valid_a = 4'b0101;
    @(negedge clk);
    chk("post_reset_grant", req_ready_a, 4'b0001);
    @(posedge clk); #1 req_valid_a = '0;
    wait_rsp_a();
    @(posedge clk); #1;

    // Full truth-table sweep through requester 2, vector scrambled after accept.
    for (int i = 0; i < 16; i++) begin
      do_txn(2, 4'(i), 1, lat, rid, res);
      chk($sformatf("sweep_out_%0d", i), res, exp_tt[i]);
      chk("sweep_id", rid, 2);
      chk("sweep_latency", lat, 5);
    end

    // SETTLE=1 instance, requester 1 held valid.
    req_vec_b = 16'h00A0;
    req_valid_b = 4'b0010;
    repeat (20) begin
      @(negedge clk);
      if (req_ready_b[1]) acc_b.push_back(cyc);
      if (rsp_valid_b) rsp_b.push_back(cyc);
    end
    @(posedge clk); #1 req_valid_b = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("b_accepts", acc_b.size() >= 4, 1);
    chk("b_responses", rsp_b.size() >= 3, 1);
    if (acc_b.size() >= 4 && rsp_b.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("b_accept_spacing", acc_b[k+1] - acc_b[k], 3);
        chk("b_rsp_latency", rsp_b[k] - acc_b[k], 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/c766_eval_arbiter.md
C766_EVAL_ARBITER -- requirements
Module: c766_eval_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesters (2..8).
REQ-002 Parameter SETTLE, 4, cycles the applied vector is held before sampling (1..15).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NREQ  per-requester evaluation request.
REQ-007 req_vec  in  4*NREQ  per-requester vector, slice i = {in1,in2,in3,in4}, in1 MSB.
REQ-008 req_ready  out  NREQ  one-hot grant/accept strobe.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer accepts result.
REQ-011 rsp_id  out  clog2(NREQ)  index of requester owning the result.
REQ-012 rsp_out  out  1  function value for the granted vector.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 Function SHALL be f = TT[15-idx], TT = 16'hC766, idx = {in1,in2,in3,in4}; row 0 is TT MSB.
REQ-015 FSM SHALL have states IDLE, SETTLE, RESP, one shared evaluator instance.
REQ-016 IDLE: if any req_valid, winner = first valid at or after rr_ptr, wrapping; req_ready[winner]=1 that cycle only; handshake completes; vector and id latched; go SETTLE with counter = SETTLE-1.
REQ-017 req_ready SHALL be all-zero outside IDLE and in IDLE with no valid request; never more than one bit high.
REQ-018 SETTLE: evaluator inputs driven only from latched vector; counter decrements; at counter 0, rsp_out registered from evaluator output, go RESP.
REQ-019 Latency: acceptance in cycle t SHALL give first rsp_valid in cycle t+SETTLE+1.
REQ-020 RESP: rsp_valid=1, rsp_id, rsp_out stable until rsp_valid && rsp_ready; then rr_ptr = (winner+1) mod NREQ, go IDLE.
REQ-021 rsp_ready high on rsp_valid's first cycle: exactly one cycle of rsp_valid; new grant possible the following cycle.
REQ-022 req_valid/req_vec changes of non-granted requesters SHALL be ignored; requests withdrawn before grant are not served.
REQ-023 Changes on req_vec after acceptance SHALL not affect the pending result.
REQ-024 rr_ptr wraps NREQ-1 -> 0; rr_ptr advances only on response handshake.

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, rr_ptr 0, counter 0, latched vector 0, rsp_valid 0, rsp_id 0, rsp_out 0, req_ready 0, busy 0.
REQ-026 Reset during SETTLE or RESP SHALL abort the evaluation with no response issued; first grant after release follows REQ-016 from rr_ptr 0.

Structure
REQ-027 Shared package c766_pkg SHALL hold TT constant 16'hC766, vector width 4, FSM state enum.
REQ-028 Evaluator SHALL be one combinational sub-module c766_core (4 in, 1 out) instantiated once; no sequential logic in it.

Verification
REQ-029 Single requester 0, vecs 0000/0011/0101/1010/1111, SETTLE=4, rsp_ready=1 -> rsp_out 1/0/1/1/0, rsp_id 0, rsp_valid 5 cycles after accept.
REQ-030 Post-reset, all four req_valid high held -> grants in order 0,1,2,3,0; one req_ready bit per grant.
REQ-031 rsp_ready low 6 cycles in RESP -> rsp_valid, rsp_id, rsp_out stable; req_ready all 0; grant resumes cycle after handshake.
REQ-032 rst_n pulsed low in 2nd SETTLE cycle -> all outputs 0 immediately; no rsp_valid; next request granted from requester 0.
REQ-033 Sweep idx 0..15 via requester 2, req_vec changed right after accept -> results equal TT[15-idx], unaffected by changes.
REQ-034 SETTLE=1 with rsp_ready high, requester 1 continuously valid -> accept every 3rd cycle, rsp_valid 2 cycles after each accept.
